midi_voice_allocator: RTL and testbench
=======================================

// Module: midi_voice_allocator
// PURPOSE
// - Polyphonic voice scheduler between uart_midi_rx and the per-voice synthesizer/ADSR datapath.
// - Shares N_VOICES oscillator voices among incoming MIDI notes.
// - Assigns note-ons to free voices, retriggers repeated notes and frees voices on note-off.
// - When all voices are busy, steals the oldest voice.
// - Runs in the clk_98_3mhz domain.
// PARAMETERS
// - N_VOICES  default 4    number of voices; >=2.
// - AGE_BITS  default 8    width of the per-voice saturating age counter.
// PORTS
// - clk_in           in   1            system clock (clk_98_3mhz).
// - rst_in           in   1            synchronous, active-high reset.
// - valid_in         in   1            event strobe from uart_midi_rx.
// - midi_event       in   24           [23:16] status, [15:8] note, [7:0] velocity.
// - ready_out        out  1            high when in IDLE; an event is accepted on valid_in && ready_out.
// - voice_note_out   out  7*N_VOICES   MIDI note per voice; voice v at [7v+6:7v].
// - voice_vel_out    out  7*N_VOICES   velocity per voice; voice v at [7v+6:7v].
// - voice_gate_out   out  N_VOICES     1 = voice holds a sounding note.
// - voice_trig_out   out  N_VOICES     one-cycle pulse on (re)allocation; restarts ADSR/phase.
// - dropped_out      out  1            sticky; set when valid_in arrives while ready_out=0.
// BEHAVIOUR
// Reset
// - Synchronous. All voice_*_out = 0, ages = 0, dropped_out = 0, FSM in IDLE, ready_out = 1.
// - Reset mid-scan aborts the event: no commit, no trig.
// Decode, applied at accept
// - Status 0x9n with velocity != 0 is NOTE_ON.
// - Status 0x8n, or 0x9n with velocity 0, is NOTE_OFF.
// - Any other status is NOP: it still walks the FSM but commits nothing.
// - Channel nibble is ignored (omni). Note and velocity use bits [6:0] only.
// FSM: IDLE -> SCAN -> COMMIT -> IDLE
// - IDLE: on valid_in, latch event, idx = 0, go to SCAN.
// - SCAN: examines voice idx once per cycle, N_VOICES cycles. Tracks:
//   - match: first voice with gate=1 and equal note.
//   - free: lowest-index voice with gate=0.
//   - oldest: gate=1 voice with maximum age; ties go to the lower index.
//   - After idx == N_VOICES-1, go to COMMIT.
// - COMMIT (one cycle), then return to IDLE:
//   - NOTE_ON, target = match if any, else free if any, else oldest (steal).
//     - Target gets note, vel, gate=1, age=0, trig pulse.
//     - Every other gate=1 voice: age+1, saturating at 2^AGE_BITS-1.
//     - Retrigger (match) updates velocity and does not age the target.
//   - NOTE_OFF with match: gate=0 on the match. Note, vel and age are held; no trig.
//   - NOTE_OFF with no match: no change.
// Timing
// - Accept edge = cycle 0. Outputs change at the end of cycle N_VOICES+1.
// - voice_trig_out is high for exactly cycle N_VOICES+2, then 0.
// - ready_out = 0 from cycle 1 through N_VOICES+1. Throughput is 1 event per N_VOICES+2 cycles.
// - A valid_in while ready_out=0 is not queued: the event is discarded and dropped_out is set until reset.
// - valid_in in the same cycle that FSM returns to IDLE is accepted normally.
// - Outputs are registered. voice_gate_out never glitches between commits.
// TESTING (N_VOICES=4)
// - Reset -> all gates 0, ready 1.
//   Then 90 3C 64 -> voice0 note=60 vel=100 gate=1, trig[0] one cycle at cycle 6.
// - Note-ons 60,62,64,67 -> voices 0..3 gated.
//   Then 90 48 7F with no free voice -> steals voice0 (age 3, oldest), voice0 note=72, trig[0].
// - Voices 0..3 hold 60,62,64,67; send 80 3E 00 -> voice1 gate=0, others unchanged.
//   Then 90 41 50 -> lands in voice1.
// - 90 3C 64 then 90 3C 20 -> same voice0 retriggered, vel=32, trig[0], no second voice used.
//   Then 90 3C 00 -> voice0 gate 0.
// - Second valid_in 2 cycles after an accept -> ignored, dropped_out=1 and stays 1.
//   B0 07 7F (CC) -> no output change, ready back after 6 cycles.
// - rst_in asserted during SCAN of a note-on -> after reset, all gates 0 and no trig pulse ever appears.

Source files
------------

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice scheduler: maps incoming MIDI note events onto N_VOICES oscillator voices.
// The voice table is scanned serially once per event. The oldest sounding voice is stolen when no voice is free.
module midi_voice_allocator #(
  parameter int N_VOICES = 4,
  parameter int AGE_BITS = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    valid_in,
  input  logic [23:0]             midi_event,
  output logic                    ready_out,
  output logic [7*N_VOICES-1:0]   voice_note_out,
  output logic [7*N_VOICES-1:0]   voice_vel_out,
  output logic [N_VOICES-1:0]     voice_gate_out,
  output logic [N_VOICES-1:0]     voice_trig_out,
  output logic                    dropped_out
);

  localparam int IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VOICES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;
  typedef enum logic [1:0] {EV_NOP, EV_ON, EV_OFF} ev_t;

  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  ev_t ev_q;
  logic [6:0] ev_note_q, ev_vel_q;

  logic [6:0]          note_q [N_VOICES];
  logic [6:0]          vel_q  [N_VOICES];
  logic [AGE_BITS-1:0] age_q  [N_VOICES];
  logic [N_VOICES-1:0] gate_q, trig_q;
  logic                dropped_q;

  logic                match_vld_q, free_vld_q, old_vld_q;
  logic [IDX_W-1:0]    match_idx_q, free_idx_q, old_idx_q, target;
  logic [AGE_BITS-1:0] old_age_q;
  logic                unused_bits;

  function automatic logic [AGE_BITS-1:0] age_sat_inc(input logic [AGE_BITS-1:0] a);
    return (&a) ? a : a + 1'b1;
  endfunction

  function automatic ev_t decode_event(input logic [23:0] ev);
    if (ev[23:20] == 4'h9 && ev[6:0] != 7'd0) return EV_ON;
    if (ev[23:20] == 4'h9 || ev[23:20] == 4'h8) return EV_OFF;
    return EV_NOP;
  endfunction

  // Channel nibble and the MIDI data-byte MSBs carry no information here.
  assign unused_bits = ^{midi_event[19:16], midi_event[15], midi_event[7]};

  assign ready_out   = (state_q == S_IDLE);
  assign dropped_out = dropped_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (valid_in) state_d = S_SCAN;
      S_SCAN:   if (idx_q == LAST_IDX) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Event latch and scan trackers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      idx_q       <= '0;
      ev_q        <= EV_NOP;
      ev_note_q   <= '0;
      ev_vel_q    <= '0;
      match_vld_q <= 1'b0;
      free_vld_q  <= 1'b0;
      old_vld_q   <= 1'b0;
      match_idx_q <= '0;
      free_idx_q  <= '0;
      old_idx_q   <= '0;
      old_age_q   <= '0;
    end else if (state_q == S_IDLE) begin
      if (valid_in) begin
        idx_q       <= '0;
        ev_q        <= decode_event(midi_event);
        ev_note_q   <= midi_event[14:8];
        ev_vel_q    <= midi_event[6:0];
        match_vld_q <= 1'b0;
        free_vld_q  <= 1'b0;
        old_vld_q   <= 1'b0;
      end
    end else if (state_q == S_SCAN) begin
      if (gate_q[idx_q]) begin
        if (!match_vld_q && note_q[idx_q] == ev_note_q) begin
          match_vld_q <= 1'b1;
          match_idx_q <= idx_q;
        end
        // Strict compare keeps the lower index on equal ages.
        if (!old_vld_q || age_q[idx_q] > old_age_q) begin
          old_vld_q <= 1'b1;
          old_idx_q <= idx_q;
          old_age_q <= age_q[idx_q];
        end
      end else if (!free_vld_q) begin
        free_vld_q <= 1'b1;
        free_idx_q <= idx_q;
      end
      idx_q <= idx_q + 1'b1;
    end
  end

  always_comb begin
    target = old_idx_q;
    if (match_vld_q)     target = match_idx_q;
    else if (free_vld_q) target = free_idx_q;
  end

  // Commit into the voice table
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      gate_q <= '0;
      trig_q <= '0;
      for (int v = 0; v < N_VOICES; v++) begin
        note_q[v] <= '0;
        vel_q[v]  <= '0;
        age_q[v]  <= '0;
      end
    end else begin
      trig_q <= '0;
      if (state_q == S_COMMIT) begin
        if (ev_q == EV_ON) begin
          for (int v = 0; v < N_VOICES; v++) begin
            if (IDX_W'(v) == target) begin
              note_q[v] <= ev_note_q;
              vel_q[v]  <= ev_vel_q;
              age_q[v]  <= '0;
              gate_q[v] <= 1'b1;
              trig_q[v] <= 1'b1;
            end else if (gate_q[v]) begin
              age_q[v] <= age_sat_inc(age_q[v]);
            end
          end
        end else if (ev_q == EV_OFF && match_vld_q) begin
          gate_q[match_idx_q] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in)                     dropped_q <= 1'b0;
    else if (valid_in && !ready_out) dropped_q <= 1'b1;
  end

  always_comb begin
    voice_note_out = '0;
    voice_vel_out  = '0;
    for (int v = 0; v < N_VOICES; v++) begin
      voice_note_out[7*v +: 7] = note_q[v];
      voice_vel_out[7*v +: 7]  = vel_q[v];
    end
  end

  assign voice_gate_out = gate_q;
  assign voice_trig_out = trig_q;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed bench for midi_voice_allocator with N_VOICES=4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_midi_voice_allocator;

  localparam int NV = 4;

  logic            clk_in = 1'b0;
  logic            rst_in = 1'b1;
  logic            valid_in = 1'b0;
  logic [23:0]     midi_event = '0;
  logic            ready_out;
  logic [7*NV-1:0] voice_note_out, voice_vel_out;
  logic [NV-1:0]   voice_gate_out, voice_trig_out;
  logic            dropped_out;

  int checks = 0;
  int failures = 0;

  midi_voice_allocator #(.N_VOICES(NV), .AGE_BITS(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .midi_event(midi_event),
    .ready_out(ready_out), .voice_note_out(voice_note_out), .voice_vel_out(voice_vel_out),
    .voice_gate_out(voice_gate_out), .voice_trig_out(voice_trig_out), .dropped_out(dropped_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #1_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] note_of(input int v);
    return voice_note_out[7*v +: 7];
  endfunction

  function automatic logic [6:0] vel_of(input int v);
    return voice_vel_out[7*v +: 7];
  endfunction

  task automatic do_reset();
    rst_in = 1'b1;
    valid_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
  endtask

  // Present one event for one cycle. On return the bench sits in cycle 1 after the accept edge.
  task automatic send(input logic [23:0] ev);
    @(negedge clk_in);
    valid_in = 1'b1;
    midi_event = ev;
    @(negedge clk_in);
    valid_in = 1'b0;
  endtask

  // Full event with handshake and trigger-timing checks. On return the bench sits in cycle 7.
  task automatic do_event(input string tag, input logic [23:0] ev, input logic [NV-1:0] exp_trig);
    send(ev);
    repeat (4) @(negedge clk_in);
    chk({tag, "_ready_c5"}, 32'(ready_out), 32'd0);
    chk({tag, "_trig_c5"}, 32'(voice_trig_out), 32'd0);
    @(negedge clk_in);
    chk({tag, "_ready_c6"}, 32'(ready_out), 32'd1);
    chk({tag, "_trig_c6"}, 32'(voice_trig_out), 32'(exp_trig));
    @(negedge clk_in);
    chk({tag, "_trig_c7"}, 32'(voice_trig_out), 32'd0);
  endtask

  initial begin
    logic [NV-1:0] trig_or;

    // Reset state
    do_reset();
    chk("rst_gate", 32'(voice_gate_out), 32'd0);
    chk("rst_ready", 32'(ready_out), 32'd1);
    chk("rst_trig", 32'(voice_trig_out), 32'd0);
    chk("rst_dropped", 32'(dropped_out), 32'd0);
    chk("rst_notes", 32'(voice_note_out), 32'd0);

    // First note-on lands in voice 0
    do_event("on60", 24'h903C64, 4'b0001);
    chk("on60_note0", 32'(note_of(0)), 32'd60);
    chk("on60_vel0", 32'(vel_of(0)), 32'd100);
    chk("on60_gate", 32'(voice_gate_out), 32'b0001);

    // Fill the remaining voices, then steal the oldest (voice 0)
    do_event("on62", 24'h903E40, 4'b0010);
    do_event("on64", 24'h904040, 4'b0100);
    do_event("on67", 24'h904340, 4'b1000);
    chk("full_gate", 32'(voice_gate_out), 32'b1111);
    do_event("steal", 24'h90487F, 4'b0001);
    chk("steal_note0", 32'(note_of(0)), 32'd72);
    chk("steal_vel0", 32'(vel_of(0)), 32'd127);
    chk("steal_note1", 32'(note_of(1)), 32'd62);
    chk("steal_note3", 32'(note_of(3)), 32'd67);
    chk("steal_gate", 32'(voice_gate_out), 32'b1111);

    // Note-off frees voice 1, next note-on reuses it
    do_reset();
    do_event("l60", 24'h903C40, 4'b0001);
    do_event("l62", 24'h903E40, 4'b0010);
    do_event("l64", 24'h904040, 4'b0100);
    do_event("l67", 24'h904340, 4'b1000);
    do_event("off62", 24'h803E00, 4'b0000);
    chk("off62_gate", 32'(voice_gate_out), 32'b1101);
    chk("off62_note1", 32'(note_of(1)), 32'd62);
    chk("off62_note2", 32'(note_of(2)), 32'd64);
    do_event("on65", 24'h904150, 4'b0010);
    chk("on65_note1", 32'(note_of(1)), 32'd65);
    chk("on65_vel1", 32'(vel_of(1)), 32'd80);
    chk("on65_gate", 32'(voice_gate_out), 32'b1111);

    // Retrigger of the same note, then note-on with velocity 0 acts as note-off
    do_reset();
    do_event("rt1", 24'h903C64, 4'b0001);
    do_event("rt2", 24'h903C20, 4'b0001);
    chk("rt_vel0", 32'(vel_of(0)), 32'd32);
    chk("rt_gate", 32'(voice_gate_out), 32'b0001);
    do_event("vel0off", 24'h903C00, 4'b0000);
    chk("vel0off_gate", 32'(voice_gate_out), 32'b0000);
    chk("vel0off_note0", 32'(note_of(0)), 32'd60);

    // Event arriving while busy is dropped; sticky flag
    send(24'h904040);
    @(negedge clk_in);
    valid_in = 1'b1;
    midi_event = 24'h904540;
    @(negedge clk_in);
    valid_in = 1'b0;
    chk("drop_flag", 32'(dropped_out), 32'd1);
    repeat (3) @(negedge clk_in);
    chk("drop_trig_c6", 32'(voice_trig_out), 32'b0001);
    chk("drop_note0", 32'(note_of(0)), 32'd64);
    chk("drop_gate", 32'(voice_gate_out), 32'b0001);
    @(negedge clk_in);

    // Control change is a no-op but still walks the FSM
    do_event("cc", 24'hB0077F, 4'b0000);
    chk("cc_gate", 32'(voice_gate_out), 32'b0001);
    chk("cc_note0", 32'(note_of(0)), 32'd64);
    chk("cc_vel0", 32'(vel_of(0)), 32'd64);
    chk("cc_dropped", 32'(dropped_out), 32'd1);

    // Reset during scan aborts the note-on
    send(24'h903C64);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    trig_or = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      trig_or = trig_or | voice_trig_out;
    end
    chk("abort_trig", 32'(trig_or), 32'd0);
    chk("abort_gate", 32'(voice_gate_out), 32'd0);
    chk("abort_ready", 32'(ready_out), 32'd1);
    chk("abort_dropped", 32'(dropped_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
